// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared definitions for the serial RAM image loader.
//   state_t : loader FSM states
//   err_t   : error code driven on ram_loader.err
//   helpers : state-class decodes shared by the top and its timer hookup
package ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_VERIFY = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CSUM = 2'b01,
    ERR_RDBK = 2'b10,
    ERR_TMO  = 2'b11
  } err_t;

  // States that take bytes from the input stream.
  function automatic logic st_accepts(state_t s);
    return s inside {ST_IDLE, ST_ADDR, ST_LEN, ST_DATA, ST_CHK, ST_ERR};
  endfunction

  // Frame-body states guarded by the idle-cycle timeout.
  function automatic logic st_timed(state_t s);
    return s inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
  endfunction

  // Frame in progress.
  function automatic logic st_busy(state_t s);
    return s inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK, ST_VERIFY};
  endfunction

endpackage

// File: rtl/loader_timer.sv
// loader_timer: idle-cycle watchdog for the frame body.
//   clk, rst : clock, synchronous active-high reset
//   run      : watchdog armed (frame-body states)
//   kick     : a byte was accepted this cycle; restarts the count
//   expired  : this cycle is idle cycle number TIMEOUT since the last byte
module loader_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  // The count only has to reach TIMEOUT-1; the TIMEOUT-th idle cycle fires.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || kick) cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end

  assign expired = run && !kick && (cnt == LAST);

endmodule

// File: rtl/ram_loader.sv
// ram_loader: receives a framed RAM image over a byte stream, writes it to an
// external RAM, then reads it back and checks it before releasing the CPU.
// Frame: SYNC_BYTE, A, L, N data bytes (N = L, or 256 when L = 0), C.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_data  : incoming byte stream, in_ready handshake
//   MemWrite/MemRead  : RAM strobes (registered), addr/wdata registered
//   rdata             : combinational RAM read data
//   busy/done/err     : status, cpu_hold low only once the image is verified
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       MemWrite,
  output logic       MemRead,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic       cpu_hold
);

  state_t     state;
  err_t       err_q;
  logic [7:0] base, len, idx;
  logic [7:0] csum;   // running frame checksum: A + L + data (+ C at check)
  logic [7:0] dsum;   // sum of the data bytes as received
  logic [7:0] rsum;   // sum of the data bytes as read back

  logic       take, last, tmo;
  logic [7:0] csum_nx, rsum_nx;

  assign in_ready = st_accepts(state);
  assign busy     = st_busy(state);
  assign done     = (state == ST_DONE);
  assign cpu_hold = (state != ST_DONE);
  assign err      = err_q;

  assign take    = in_valid && in_ready;
  // idx counts 0..N-1; L-1 mod 256 is N-1 for L=0 (N=256) as well.
  assign last    = (idx == len - 8'd1);
  assign csum_nx = csum + in_data;
  assign rsum_nx = rsum + rdata;

  loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (st_timed(state)),
    .kick    (take),
    .expired (tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      err_q    <= ERR_NONE;
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      base     <= '0;
      len      <= '0;
      idx      <= '0;
      csum     <= '0;
      dsum     <= '0;
      rsum     <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (take && in_data == SYNC_BYTE) begin
            state <= ST_ADDR;
            err_q <= ERR_NONE;
          end
        end
        ST_ADDR: begin
          if (take) begin
            base  <= in_data;
            csum  <= in_data;
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (take) begin
            len   <= in_data;
            csum  <= csum_nx;
            idx   <= '0;
            dsum  <= '0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (take) begin
            MemWrite <= 1'b1;
            addr     <= base + idx;
            wdata    <= in_data;
            csum     <= csum_nx;
            dsum     <= dsum + in_data;
            if (last) begin
              idx   <= '0;
              state <= ST_CHK;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        ST_CHK: begin
          if (take) begin
            if (csum_nx == 8'd0) begin
              state   <= ST_VERIFY;
              MemRead <= 1'b1;
              addr    <= base;
              idx     <= '0;
              rsum    <= '0;
            end else begin
              state <= ST_ERR;
              err_q <= ERR_CSUM;
            end
          end
        end
        ST_VERIFY: begin
          // rdata belongs to the address presented this cycle.
          rsum <= rsum_nx;
          if (last) begin
            if (rsum_nx == dsum) state <= ST_DONE;
            else begin
              state <= ST_ERR;
              err_q <= ERR_RDBK;
            end
          end else begin
            MemRead <= 1'b1;
            addr    <= base + idx + 8'd1;
            idx     <= idx + 8'd1;
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
      // Only fires on idle cycles, so it never races an accepted byte.
      if (tmo) begin
        state <= ST_ERR;
        err_q <= ERR_TMO;
      end
    end
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, is the frame start marker.
REQ-002 Parameter TIMEOUT, default 255, is the maximum number of idle cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  an incoming byte is present on in_data.
REQ-006 in_data  input  8  incoming byte stream.
REQ-007 in_ready  output  1  loader can accept a byte; a byte transfers on an edge where in_valid and in_ready are both 1.
REQ-008 MemWrite  output  1  RAM write strobe.
REQ-009 MemRead  output  1  RAM read enable.
REQ-010 addr  output  8  RAM address.
REQ-011 wdata  output  8  RAM write data.
REQ-012 rdata  input  8  RAM combinational read data, valid in the same cycle MemRead=1.
REQ-013 busy  output  1  a frame is in progress (states ADDR through VERIFY).
REQ-014 done  output  1  image loaded and verified.
REQ-015 err  output  2  error code: 00 none, 01 checksum, 10 readback, 11 timeout.
REQ-016 cpu_hold  output  1  holds the CPU stalled; 1 in every state except DONE.

Function
REQ-017 Frame format SHALL be: SYNC_BYTE, start address A, length L, then N data bytes, then checksum C; N = L, except L=0 gives N=256.
REQ-018 A frame SHALL be valid when the 8-bit sum of A, L, all data bytes and C is 0.
REQ-019 States SHALL be IDLE, ADDR, LEN, DATA, CHK, VERIFY, DONE, ERR.
REQ-020 IDLE: in_ready=1; a byte equal to SYNC_BYTE SHALL go to ADDR; any other byte SHALL be discarded.
REQ-021 ADDR SHALL capture A; LEN SHALL capture L.
REQ-022 DATA: each accepted byte i SHALL produce MemWrite=1, addr=A+i (mod 256), wdata=byte in the following cycle; registered outputs give 1-cycle latency.
REQ-023 In DATA, in_ready SHALL stay 1 so back-to-back bytes write on consecutive cycles; after byte N-1 the state SHALL be CHK.
REQ-024 The address SHALL wrap from 8'hFF to 8'h00 without error.
REQ-025 CHK: a bad sum SHALL go to ERR with err=01; a good sum SHALL go to VERIFY.
REQ-026 VERIFY: in_ready=0; for N cycles drive MemRead=1 with addr=A+i, accumulating rdata into an 8-bit sum.
REQ-027 At the end of VERIFY, a match with the 8-bit sum of the received data SHALL go to DONE; a mismatch SHALL go to ERR with err=10.
REQ-028 MemWrite and MemRead SHALL never both be 1; outside DATA writes and VERIFY they SHALL both be 0.
REQ-029 In ADDR, LEN, DATA and CHK, an idle-cycle counter SHALL reset on every accepted byte; reaching TIMEOUT SHALL go to ERR with err=11.
REQ-030 DONE: done=1, cpu_hold=0, in_ready=0; the state SHALL be held until rst.
REQ-031 ERR: in_ready=1; a SYNC_BYTE SHALL clear err and go to ADDR; other bytes SHALL be ignored.
REQ-032 Bytes already written to RAM SHALL NOT be rolled back on error.

Reset
REQ-033 rst SHALL force IDLE: in_ready=1, MemWrite=0, MemRead=0, addr=0, wdata=0, busy=0, done=0, err=00, cpu_hold=1; counters and sums SHALL be 0.
REQ-034 rst asserted mid-frame SHALL abort the frame immediately; no further RAM strobes SHALL follow.

Structure
REQ-035 State encodings and error codes SHALL live in the shared package ram_loader_pkg.
REQ-036 The idle-cycle timeout counter SHALL be the sub-module loader_timer; the RAM is instantiated outside this block.

Verification
REQ-037 Frame A5 10 03 01 02 03 E7 -> writes 01/02/03 to 0x10..0x12, VERIFY reads 3 bytes, done=1, cpu_hold=0, err=00.
REQ-038 Frame A5 FE 04 AA BB CC DD F0 -> writes to 0xFE, 0xFF, 0x00, 0x01 (wrap); done=1.
REQ-039 Frame A5 10 03 01 02 03 E6 -> err=01, cpu_hold=1; a following good frame -> done=1, err=00.
REQ-040 RAM model corrupting location 0x11 -> err=10 after VERIFY.
REQ-041 A5 20 then in_valid low for 255 cycles -> err=11. Separately, rst asserted after the 2nd data byte -> IDLE, no further MemWrite.
REQ-042 L=0 with 256 data bytes from A=0x00 -> full RAM written, 256 VERIFY cycles, done=1.
